mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/mem_stage_load_extract.sv | 34 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, FSM state type and helpers for the data-memory stage.
package mips_pkg;

   // Access size encodings on mem_size_EM; 2'b11 is handled like a word.
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Default number of BUSY cycles allowed before declaring a bus error.
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // What the load path needs to remember about the access in flight.
   typedef struct packed {
      logic [1:0] addr_lo;
      logic [1:0] size;
      logic       is_unsigned;
   } load_info_t;

   // Little-endian byte-lane enables for an access of the given size.
   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: byte_enable = 4'b0001 << addr_lo;
         SIZE_HALF: byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   byte_enable = 4'b1111;
      endcase
   endfunction

   // Store data replicated across every lane the access could target.
   function automatic logic [31:0] write_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_BYTE: write_lanes = {4{data[7:0]}};
         SIZE_HALF: write_lanes = {2{data[15:0]}};
         default:   write_lanes = data;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_extract.sv
// load_extract: picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_extract
   import mips_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by extension to 32 bits.
   always_comb begin
      // NOTE: every output of a combinational block gets a value before any branch, so no latch is inferred.
      byte_sel = rdata[7:0];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      result   = rdata;
      case (addr_lo)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      case (size)
         SIZE_BYTE: result = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SIZE_HALF: result = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a req/ack data-memory port with a bus timeout.
// Optional build macro DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of truncating them.
module mem_stage
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_EM,
   input  logic        mem_read_EM,
   input  logic        mem_write_EM,
   input  logic [1:0]  mem_size_EM,
   input  logic        mem_unsigned_EM,
   input  logic [31:0] ALU_result_EM,
   input  logic [31:0] write_data_EM,
   input  logic [4:0]  reg_write_addr_EM,
   input  logic [1:0]  control_EM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] ALU_result_M,
   output logic [31:0] mem_read_data_M,
   output logic [4:0]  reg_write_addr_M,
   output logic [1:0]  control_M,
   output logic        stall_M,
   output logic        bus_error_M,
   output logic        misalign_M
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic [7:0]  wait_count;
   load_info_t  load_info;
   logic        access_req, accept, timeout, ack_done;
   logic [31:0] extracted;

   assign access_req = valid_EM & (mem_read_EM | mem_write_EM);

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((mem_size_EM == SIZE_HALF) & ALU_result_EM[0])
                     | (mem_size_EM[1] & (ALU_result_EM[1:0] != 2'b00));
   assign misalign_M = (state == IDLE) & access_req & misaligned;
`else
   assign misalign_M = 1'b0;
`endif

   assign accept   = (state == IDLE) & access_req & ~misalign_M;
   assign timeout  = (state == BUSY) & (wait_count == LAST_WAIT) & ~dmem_ack;
   assign ack_done = (state == BUSY) & dmem_ack;

   assign dmem_req         = (state == BUSY);
   assign bus_error_M      = timeout;
   assign ALU_result_M     = ALU_result_EM;
   assign reg_write_addr_M = reg_write_addr_EM;
   assign control_M        = (bus_error_M | misalign_M) ? 2'b00 : control_EM;
   assign mem_read_data_M  = (ack_done & ~dmem_we) ? extracted : 32'b0;

   load_extract u_load_extract (
      .rdata       (dmem_rdata),
      .addr_lo     (load_info.addr_lo),
      .size        (load_info.size),
      .is_unsigned (load_info.is_unsigned),
      .result      (extracted)
   );

   // State register; reset abandons any access in flight.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and stall decode.
   always_comb begin
      state_next = state;
      stall_M    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = BUSY;
               stall_M    = 1'b1;
            end
         end
         BUSY: begin
            stall_M = ~dmem_ack & ~timeout;
            if (dmem_ack | timeout) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Wait counter: counts BUSY cycles spent waiting, cleared when the access ends.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                               wait_count <= 8'd0;
      else if ((state == BUSY) && stall_M)      wait_count <= wait_count + 8'd1;
      else                                      wait_count <= 8'd0;
   end

   // Request capture on accept; held steady for the whole BUSY phase.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: these are a handful of control/data flops, not a memory array, so all of them reset.
      if (!reset) begin
         dmem_addr  <= 32'b0;
         dmem_be    <= 4'b0;
         dmem_wdata <= 32'b0;
         dmem_we    <= 1'b0;
         load_info  <= '0;
      end else if (accept) begin
         dmem_addr  <= {ALU_result_EM[31:2], 2'b00};
         dmem_be    <= byte_enable(mem_size_EM, ALU_result_EM[1:0]);
         dmem_wdata <= write_lanes(mem_size_EM, write_data_EM);
         dmem_we    <= mem_write_EM;
         load_info  <= '{addr_lo: ALU_result_EM[1:0], size: mem_size_EM, is_unsigned: mem_unsigned_EM};
      end
   end

endmodule
